// File: rtl/noise_rd_pkg.sv
// rtl/noise_rd_pkg.sv - shared types and constants for the Rx noise table reader
package noise_rd_pkg;
   localparam int NOISE_TBL_DEPTH = 128;
   localparam int DEF_ADDR_W      = 7;
   localparam int DEF_DATA_W      = 8;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} rd_state_t;
   typedef logic signed [DEF_DATA_W-1:0] noise_sample_t;
endpackage

// File: rtl/noise_fifo.sv
// rtl/noise_fifo.sv - first-word-fall-through sample FIFO; push and pop may coincide when full
module noise_fifo #(
   parameter int FIFO_DEPTH = 4,
   parameter int DATA_W     = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        push,
   input  logic                        pop,
   input  logic [DATA_W-1:0]           din,
   output logic [DATA_W-1:0]           dout,
   output logic                        empty,
   output logic                        full,
   output logic [$clog2(FIFO_DEPTH):0] count
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    count_q, count_d;
   logic              do_push, do_pop;

   always_comb begin
      empty    = (count_q == '0);
      full     = (count_q == (PTR_W+1)'(FIFO_DEPTH));
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
endmodule

// File: rtl/noise_mem_reader.sv
// rtl/noise_mem_reader.sv - cyclic Avalon-MM reader of the Rx noise table feeding a sample stream
// Define NOISE_SCALE_EN to add the scale port (arithmetic right shift of captured samples).
module noise_mem_reader
   import noise_rd_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int RD_LAT     = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                stop,
   output logic [ADDR_W-1:0]   address,
   output logic                chipselect,
   output logic                clken,
   output logic                write,
   output logic [DATA_W/8-1:0] byteenable,
   output logic [DATA_W-1:0]   writedata,
   input  logic [DATA_W-1:0]   readdata,
   output logic [DATA_W-1:0]   noise_data,
   output logic                noise_valid,
   input  logic                noise_ready,
`ifdef NOISE_SCALE_EN
   input  logic [2:0]          scale,
`endif
   output logic [15:0]         wrap_cnt,
   output logic                busy
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

   rd_state_t         state_q, state_d;
   logic [ADDR_W-1:0] address_q, address_d;
   logic [15:0]       wrap_cnt_q, wrap_cnt_d;
   logic [CNT_W-1:0]  inflight_q, inflight_d;
   logic [RD_LAT-1:0] lat_q, lat_d;
   logic [CNT_W-1:0]  fifo_count;
   logic [CNT_W:0]    occupancy;
   logic [DATA_W-1:0] push_data;
   logic              fifo_empty, unused_full, pop, ret, issue;

`ifdef NOISE_SCALE_EN
   assign push_data = $signed(readdata) >>> scale;
`else
   assign push_data = readdata;
`endif

   assign pop = !fifo_empty && noise_ready;
   assign ret = lat_q[RD_LAT-1];

   // Returns already in flight reserve FIFO slots, so a read is issued only when it is sure to fit.
   always_comb begin
      occupancy  = {1'b0, fifo_count} + {1'b0, inflight_q} - {{CNT_W{1'b0}}, pop};
      issue      = (state_q == RUN) && !stop && (occupancy < DEPTH_C);
      state_d    = state_q;
      address_d  = address_q;
      wrap_cnt_d = wrap_cnt_q;
      inflight_d = inflight_q;
      lat_d      = lat_q << 1;
      lat_d[0]   = issue;
      case (state_q)
         IDLE: if (start) begin
            state_d   = RUN;
            address_d = '0;
         end
         RUN:     if (stop) state_d = DRAIN;
         DRAIN:   if (inflight_q == '0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (issue) begin
         address_d = address_q + 1'b1;
         if (&address_q && wrap_cnt_q != 16'hFFFF) wrap_cnt_d = wrap_cnt_q + 16'd1;
      end
      case ({issue, ret})
         2'b10:   inflight_d = inflight_q + 1'b1;
         2'b01:   inflight_d = inflight_q - 1'b1;
         default: inflight_d = inflight_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         address_q  <= '0;
         wrap_cnt_q <= '0;
         inflight_q <= '0;
         lat_q      <= '0;
      end else begin
         state_q    <= state_d;
         address_q  <= address_d;
         wrap_cnt_q <= wrap_cnt_d;
         inflight_q <= inflight_d;
         lat_q      <= lat_d;
      end
   end

   noise_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .DATA_W(DATA_W)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (ret),
      .pop   (pop),
      .din   (push_data),
      .dout  (noise_data),
      .empty (fifo_empty),
      .full  (unused_full),
      .count (fifo_count)
   );

   assign address     = address_q;
   assign chipselect  = issue;
   assign clken       = 1'b1;
   assign write       = 1'b0;
   assign byteenable  = '1;
   assign writedata   = '0;
   assign noise_valid = !fifo_empty;
   assign wrap_cnt    = wrap_cnt_q;
   assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_noise_mem_reader.sv
// tb/tb_noise_mem_reader.sv - scoreboard bench for noise_mem_reader with RD_LAT=1 and RD_LAT=3 instances
module tb_noise_mem_reader;
   import noise_rd_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start, stop, rdy1, rdy3;
   logic [6:0]  addr1, addr3;
   logic        cs1, cs3, clken1, clken3, wr1, wr3, nv1, nv3, busy1, busy3;
   logic [0:0]  be1, be3;
   logic [7:0]  wd1, wd3, rdata1, rdata3, nd1, nd3;
   logic [15:0] wc1, wc3;
`ifdef NOISE_SCALE_EN
   logic [2:0]  scale = 3'd0;
`endif

   logic [7:0]  mem [128];
   logic [7:0]  p1;
   logic [7:0]  p3 [3];

   always @(posedge clk) begin
      p1    <= cs1 ? mem[addr1] : 8'hEE;
      p3[0] <= cs3 ? mem[addr3] : 8'hEE;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign rdata1 = p1;
   assign rdata3 = p3[2];

   noise_mem_reader #(.RD_LAT(1)) u_dut1 (
      .clk(clk), .reset(reset), .start(start), .stop(stop),
      .address(addr1), .chipselect(cs1), .clken(clken1), .write(wr1),
      .byteenable(be1), .writedata(wd1), .readdata(rdata1),
      .noise_data(nd1), .noise_valid(nv1), .noise_ready(rdy1),
`ifdef NOISE_SCALE_EN
      .scale(scale),
`endif
      .wrap_cnt(wc1), .busy(busy1)
   );

   noise_mem_reader #(.RD_LAT(3)) u_dut3 (
      .clk(clk), .reset(reset), .start(start), .stop(stop),
      .address(addr3), .chipselect(cs3), .clken(clken3), .write(wr3),
      .byteenable(be3), .writedata(wd3), .readdata(rdata3),
      .noise_data(nd3), .noise_valid(nv3), .noise_ready(rdy3),
`ifdef NOISE_SCALE_EN
      .scale(scale),
`endif
      .wrap_cnt(wc3), .busy(busy3)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int ntx1 = 0, ntx3 = 0, first_tx = 0, last_tx = 0;
   logic [7:0] q1 [$];
   logic [7:0] q3 [$];
   logic [7:0] e1, e3;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (nv1 && rdy1) begin
         checks++;
         if (q1.size() == 0) begin
            errors++;
            $display("FAIL sb1_extra: got %02h, required no sample", nd1);
         end else begin
            e1 = q1.pop_front();
            if (nd1 !== e1) begin
               errors++;
               $display("FAIL sb1_data: sample %0d got %02h, required %02h", ntx1, nd1, e1);
            end
         end
         if (ntx1 == 0) first_tx = cyc;
         last_tx = cyc;
         ntx1++;
      end
      if (nv3 && rdy3) begin
         checks++;
         if (q3.size() == 0) begin
            errors++;
            $display("FAIL sb3_extra: got %02h, required no sample", nd3);
         end else begin
            e3 = q3.pop_front();
            if (nd3 !== e3) begin
               errors++;
               $display("FAIL sb3_data: sample %0d got %02h, required %02h", ntx3, nd3, e3);
            end
         end
         ntx3++;
      end
   end

   task automatic apply_reset;
      reset = 1'b1; start = 1'b0; stop = 1'b0; rdy1 = 1'b0; rdy3 = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      q1.delete(); q3.delete();
      ntx1 = 0; ntx3 = 0;
   endtask

   task automatic pulse_start;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_tx1(input int n, input int budget, input string nm);
      for (int k = 0; k < budget && ntx1 < n; k++) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (ntx1 < n) begin
         errors++;
         $display("FAIL %s_timeout: got %0d samples, required %0d", nm, ntx1, n);
      end
   endtask

   task automatic test_reset;
      logic [15:0] obs [16];
      logic [15:0] req [16];
      string       nm  [16];
      reset = 1'b1; start = 1'b0; stop = 1'b0; rdy1 = 1'b0; rdy3 = 1'b0;
      @(negedge clk);
      obs = '{16'(addr1), 16'(cs1), 16'(clken1), 16'(wr1), 16'(be1), 16'(wd1), 16'(nd1), 16'(nv1),
              wc1, 16'(busy1), 16'(addr3), 16'(cs3), 16'(clken3), 16'(be3), 16'(nv3), 16'(busy3)};
      req = '{16'd0, 16'd0, 16'd1, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0,
              16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd0, 16'd0};
      nm  = '{"address", "chipselect", "clken", "write", "byteenable", "writedata", "noise_data",
              "noise_valid", "wrap_cnt", "busy", "address3", "chipselect3", "clken3", "byteenable3",
              "noise_valid3", "busy3"};
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (obs[i] !== req[i]) begin
            errors++;
            $display("FAIL reset_%s: got %0h, required %0h", nm[i], obs[i], req[i]);
         end
      end
      checks++;
      if ({wr3, wd3, nd3, wc3} !== 25'd0) begin
         errors++;
         $display("FAIL reset_dut3_zero: got %0h, required 0", {wr3, wd3, nd3, wc3});
      end
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_sweep;
      bit seen = 0;
      apply_reset();
      for (int i = 0; i < 130; i++) q1.push_back(8'(i % 128));
      rdy1 = 1'b1;
      pulse_start();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (nv1 !== (k == 2)) begin
            errors++;
            $display("FAIL first_valid: edge %0d got %b, required %b", k, nv1, (k == 2));
         end
      end
      for (int k = 0; k < 400 && ntx1 < 130; k++) begin
         @(posedge clk);
         #1;
         if (ntx1 == 120 && !seen) begin
            seen = 1;
            checks++;
            if (wc1 !== 16'd0) begin
               errors++;
               $display("FAIL wrap_before: got %0d, required 0", wc1);
            end
         end
      end
      rdy1 = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (ntx1 !== 130) begin
         errors++;
         $display("FAIL sweep_count: got %0d, required 130", ntx1);
      end
      checks++;
      if (wc1 !== 16'd1) begin
         errors++;
         $display("FAIL wrap_after: got %0d, required 1", wc1);
      end
      checks++;
      if (last_tx - first_tx !== 129) begin
         errors++;
         $display("FAIL throughput: got %0d cycles for 130 samples, required 129", last_tx - first_tx);
      end
   endtask

   task automatic test_backpressure;
      int ncs = 0;
      apply_reset();
      for (int i = 0; i < 10; i++) q1.push_back(8'(i));
      pulse_start();
      repeat (20) begin
         @(negedge clk);
         if (cs1) ncs++;
      end
      checks++;
      if (ncs !== 4) begin
         errors++;
         $display("FAIL bp_reads: got %0d, required 4", ncs);
      end
      checks++;
      if ({nv1, nd1, addr1} !== {1'b1, 8'h00, 7'd4}) begin
         errors++;
         $display("FAIL bp_hold: got valid/data/addr %b/%02h/%0d, required 1/00/4", nv1, nd1, addr1);
      end
      @(posedge clk);
      #1 rdy1 = 1'b1;
      wait_tx1(10, 60, "bp");
      rdy1 = 1'b0;
      checks++;
      if (q1.size() != 0) begin
         errors++;
         $display("FAIL bp_left: got %0d pending, required 0", q1.size());
      end
   endtask

   task automatic test_rdlat3;
      apply_reset();
      for (int i = 0; i < 128; i++) q3.push_back(8'(i));
      pulse_start();
      repeat (200) begin
         @(posedge clk);
         #1 rdy3 = ~rdy3;
      end
      rdy3 = 1'b0;
      checks++;
      if (ntx3 < 90) begin
         errors++;
         $display("FAIL lat3_rate: got %0d samples, required at least 90", ntx3);
      end
   endtask

   task automatic test_stop;
      bit found = 0;
      int extra_cs = 0;
      int drop_ntx = -1;
      apply_reset();
      for (int i = 0; i <= 10; i++) q1.push_back(8'(i));
      rdy1 = 1'b1;
      pulse_start();
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge clk);
         if (cs1 && addr1 == 7'd10) found = 1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL stop_find: got no read of address 10, required one");
      end
      @(posedge clk);
      #1 stop = 1'b1;
      @(negedge clk);
      checks++;
      if ({cs1, busy1} !== 2'b01) begin
         errors++;
         $display("FAIL stop_cycle: got cs/busy %b/%b, required 0/1", cs1, busy1);
      end
      @(posedge clk);
      #1 stop = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (cs1) extra_cs++;
         if (!busy1 && drop_ntx < 0) drop_ntx = ntx1;
         @(posedge clk);
         #1;
      end
      checks++;
      if (extra_cs !== 0) begin
         errors++;
         $display("FAIL stop_no_cs: got %0d reads, required 0", extra_cs);
      end
      checks++;
      if (drop_ntx !== 11) begin
         errors++;
         $display("FAIL stop_busy: got %0d samples at busy fall, required 11", drop_ntx);
      end
      checks++;
      if (ntx1 !== 11 || q1.size() != 0) begin
         errors++;
         $display("FAIL stop_delivered: got %0d samples, required 11", ntx1);
      end
   endtask

   task automatic test_reset_mid;
      apply_reset();
      pulse_start();
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if ({nv1, nd1} !== 9'h100) begin
         errors++;
         $display("FAIL mid_pre: got valid/data %b/%02h, required 1/00", nv1, nd1);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({nv1, nd1, cs1, addr1, wc1, busy1} !== 34'd0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got %0h, required 0", {nv1, nd1, cs1, addr1, wc1, busy1});
      end
      @(posedge clk);
      #1 reset = 1'b0;
      q1.delete();
      ntx1 = 0;
      for (int i = 0; i < 3; i++) q1.push_back(8'(i));
      rdy1 = 1'b1;
      pulse_start();
      wait_tx1(3, 20, "mid");
      rdy1 = 1'b0;
      checks++;
      if (ntx1 !== 3) begin
         errors++;
         $display("FAIL mid_count: got %0d, required 3", ntx1);
      end
   endtask

`ifdef NOISE_SCALE_EN
   task automatic test_scale;
      noise_sample_t s;
      apply_reset();
      mem[0] = 8'h80;
      scale = 3'd2;
      q1.push_back(8'hE0);
      for (int i = 1; i < 5; i++) begin
         s = noise_sample_t'(i);
         q1.push_back(8'(s >>> 2));
      end
      rdy1 = 1'b1;
      pulse_start();
      wait_tx1(5, 20, "scale");
      rdy1 = 1'b0;
      mem[0] = 8'h00;
      scale = 3'd0;
   endtask
`endif

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 8'(i);
      test_reset();
      test_sweep();
      test_backpressure();
      test_rdlat3();
      test_stop();
      test_reset_mid();
`ifdef NOISE_SCALE_EN
      test_scale();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, required finish");
      $fatal(1);
   end
endmodule
